fifo_share_scheduler: RTL
=========================

// Module: fifo_share_scheduler
// PURPOSE
//  Shares one DEPTH-deep FIFO write port among NREQ producers (round-robin) and one consumer.
//  Tracks FIFO occupancy and generates push/pop/full/empty for the FIFO and the scoreboard.
//  Sequences the scoreboard: on request, marks one chosen producer's next accepted packet as
//  the magic packet, asserts start on that push, and pulses mp_exit when the packet is popped.
// PARAMETERS
//  NREQ    4                  number of producers (>=2)
//  DEPTH   8                  FIFO capacity in entries
//  WIDTH   8                  packet width
//  CNTWID  $clog2(DEPTH)+1    occupancy counter width (holds 0..DEPTH)
//  IDXW    $clog2(NREQ)       producer index width
// PORTS
//  clk       in   1            clock, rising edge
//  rst       in   1            asynchronous, active-low reset
//  req       in   NREQ         producer i has a packet to push
//  req_data  in   NREQ*WIDTH   producer i data is slice [i*WIDTH +: WIDTH]
//  gnt       out  NREQ         one-hot: producer i push accepted this cycle
//  pop_req   in   1            consumer wants a packet
//  pop       out  1            pop issued to FIFO/scoreboard (= pop_ack)
//  push      out  1            push issued to FIFO/scoreboard (= |gnt)
//  data_in   out  WIDTH        req_data of the granted producer; 0 when push=0
//  arm       in   1            request capture of a magic packet
//  arm_src   in   IDXW         producer whose next accepted packet is captured
//  start     out  1            scoreboard capture strobe, coincident with that push
//  mp_exit   out  1            one-cycle pulse: magic packet popped
//  cnt       out  CNTWID       current occupancy (registered)
//  empty     out  1            cnt==0
//  full      out  1            cnt==DEPTH
//  trk_state out  2            capture FSM state
// BEHAVIOUR
//  Reset (rst=0, async): cnt=0, rr_ptr=0, FSM=IDLE, position=0, latched src=0.
//   Hence empty=1, full=0; gnt/push/pop/start/mp_exit=0; data_in=0 while req is masked.
//  Arbitration (combinational from registered state, zero latency):
//   - Eligible only if !full. Pushing into a full FIFO is never allowed, even when pop=1.
//   - Winner = first i with req[i], searching from rr_ptr upward with wrap (NREQ-1 -> 0).
//   - On a grant, rr_ptr <= winner+1 mod NREQ. With no grant, rr_ptr holds.
//  Pop: pop = pop_req & !empty. Popping on an empty FIFO is never allowed, even when push=1.
//  Count: cnt <= cnt + push - pop. A simultaneous push and pop leaves cnt unchanged.
//   cnt never exceeds DEPTH and never wraps below 0.
//  Capture FSM (trk_state): IDLE=0, ARMED=1, TRACK=2, DONE=3.
//   - IDLE:  arm=1 -> ARMED, latch src<=arm_src. arm in any other state is ignored.
//   - ARMED: gnt[src]=1 -> start=1 this cycle, go to TRACK,
//            pos <= cnt - pop (entries ahead of the magic packet).
//            Grants to other producers keep the FSM in ARMED.
//   - TRACK: on pop: if pos==0 -> mp_exit=1 this cycle and go to DONE; else pos <= pos-1.
//   - DONE:  unconditionally back to IDLE next cycle (one-cycle dead state; arm ignored).
//  start asserts at most once per arm. mp_exit asserts exactly once per start.
//  Async reset mid-operation: all state returns to its reset value immediately.
//   Any armed or tracked capture is abandoned; no mp_exit is produced.
// STRUCTURE
//  Package fifo_sched_pkg: trk_state_e enum (IDLE/ARMED/TRACK/DONE);
//   function clog2_min1 for IDXW when NREQ==1 would give 0.
//  Sub-module rr_arbiter #(NREQ): inputs req, rr_ptr, enable; outputs gnt, winner index.
//  Top level contains the counter, pointer register, data mux and capture FSM.
// TESTING
//  1. Reset with all inputs 0 -> cnt=0, empty=1, full=0, trk_state=0; all strobes 0.
//  2. req=4'b1111 held, pop_req=0, 10 cycles -> gnt order 0,1,2,3,0,1,2,3;
//     cnt reaches 8, full=1; then gnt=0 and push=0 for the last 2 cycles.
//  3. FIFO full, req=4'b0001, pop_req=1 for 1 cycle -> pop=1, gnt=0, cnt 8->7;
//     next cycle gnt=4'b0001, cnt=8.
//  4. Empty, req=4'b0010, pop_req=1 same cycle -> gnt=4'b0010, pop=0, cnt=1.
//  5. cnt=3, arm=1 with arm_src=2, then req=4'b0100 -> start=1 with gnt[2]; pos=3;
//     pop_req=1 for 4 pops -> mp_exit only on the 4th pop; trk_state 3 then 0.
//  6. TRACK with pos=1, drop rst to 0 for 1 cycle -> trk_state=0, cnt=0;
//     no mp_exit on later pops; a new arm is accepted.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO share scheduler: capture FSM states and
// an index-width helper that never collapses to zero bits.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } trk_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr, wrapping
// from NREQ-1 back to 0. Purely combinational.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] winner
);

  logic            found;
  logic [IDXW:0]   sum;
  logic [IDXW-1:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NREQ)) sum = sum - (IDXW+1)'(NREQ);
      idx = sum[IDXW-1:0];
      if (enable && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_share_scheduler.sv
// Shares one FIFO write port among NREQ producers (round-robin), tracks occupancy,
// and follows one "magic" packet from its push to its pop for the scoreboard.
module fifo_share_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH) + 1,
  parameter int IDXW   = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  pop_req,
  output logic                  pop,
  output logic                  push,
  output logic [WIDTH-1:0]      data_in,
  input  logic                  arm,
  input  logic [IDXW-1:0]       arm_src,
  output logic                  start,
  output logic                  mp_exit,
  output logic [CNTWID-1:0]     cnt,
  output logic                  empty,
  output logic                  full,
  output logic [1:0]            trk_state
);

  // Handshake: a producer holds req[i] and req_data until it sees gnt[i] in the
  // same cycle; the transfer happens on that clock edge. pop_req/pop behave the same.

  logic [CNTWID-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   src_q, src_d;
  logic [CNTWID-1:0] pos_q, pos_d;
  trk_state_e        state_q, state_d;
  logic [IDXW-1:0]   winner;

  assign full  = (cnt_q == CNTWID'(DEPTH));
  assign empty = (cnt_q == '0);

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .enable (!full),
    .gnt    (gnt),
    .winner (winner)
  );

  always_comb begin
    push    = |gnt;
    pop     = pop_req & !empty;
    data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) data_in = req_data[i*WIDTH +: WIDTH];
    end

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (winner == IDXW'(NREQ-1)) ? '0 : winner + 1'b1;
  end

  // Capture FSM: pos counts entries still ahead of the magic packet.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    pos_d   = pos_q;
    start   = 1'b0;
    mp_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          src_d   = arm_src;
        end
      end
      ARMED: begin
        if (gnt[src_q]) begin
          start   = 1'b1;
          state_d = TRACK;
          pos_d   = cnt_q - CNTWID'(pop);
        end
      end
      TRACK: begin
        if (pop) begin
          if (pos_q == '0) begin
            mp_exit = 1'b1;
            state_d = DONE;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      src_q    <= '0;
      pos_q    <= '0;
      state_q  <= IDLE;
    end else begin
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      pos_q    <= pos_d;
      state_q  <= state_d;
    end
  end

  assign cnt       = cnt_q;
  assign trk_state = state_q;

endmodule
